affine_interp_row_filter: RTL and testbench



---
 rtl/affine_interp_row_filter_if.sv | 32 +++
 rtl/affine_interp_row_filter.sv | 142 ++++++++++++++
 tb/tb_affine_interp_row_filter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/affine_interp_row_filter_if.sv
// Handshake bundle for affine_interp_row_filter: row control, sample in, sample out.
// With AFFINE_HIGHPREC_EN defined, out_sample is 16-bit two's complement.
interface affine_interp_row_filter_if #(
  parameter int TAPS = 6
);
`ifdef AFFINE_HIGHPREC_EN
  localparam int OUT_W = 16;
`else
  localparam int OUT_W = 8;
`endif

  logic              start;
  logic [TAPS*8-1:0] coef;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_sample;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_sample;
  logic              done;

  modport master (
    output start, coef, in_valid, in_sample, out_ready,
    input  busy, in_ready, out_valid, out_sample, done
  );

  modport slave (
    input  start, coef, in_valid, in_sample, out_ready,
    output busy, in_ready, out_valid, out_sample, done
  );
endinterface

// File: rtl/affine_interp_row_filter.sv
// Horizontal FIR row filter: sliding TAPS-deep window, row-latched coefficients,
// round/shift/clip to 8 bits (raw saturated 16-bit sum when AFFINE_HIGHPREC_EN).
module affine_interp_row_filter #(
  parameter int TAPS    = 6,
  parameter int ROW_LEN = 8,
  parameter int SHIFT   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  affine_interp_row_filter_if.slave bus
);
`ifdef AFFINE_HIGHPREC_EN
  localparam int OUT_W = 16;
`else
  localparam int OUT_W = 8;
`endif
  localparam int ACC_W = 16 + $clog2(TAPS);
  localparam int FC_W  = $clog2(TAPS);
  localparam int OC_W  = $clog2(ROW_LEN + 1);
  localparam logic [FC_W-1:0] FILL_LAST = FC_W'(TAPS - 2);
  localparam logic [OC_W-1:0] OUT_LAST  = OC_W'(ROW_LEN);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                  state, state_nx;
  logic [7:0]              win    [TAPS];
  logic signed [7:0]       coef_q [TAPS];
  logic [7:0]              taps   [TAPS];
  logic [FC_W-1:0]         fill_cnt;
  logic [OC_W-1:0]         out_cnt;
  logic                    in_fire, out_fire, last_fire;
  logic signed [15:0]      c_ext, s_ext, prod;
  logic signed [ACC_W-1:0] sum;
  logic [OUT_W-1:0]        result;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_fire = (state == RUN) && out_fire && (out_cnt == OUT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nx     = state;
    bus.in_ready = 1'b0;
    bus.busy     = (state != IDLE);
    case (state)
      IDLE: if (bus.start) state_nx = FILL;
      FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && fill_cnt == FILL_LAST) state_nx = RUN;
      end
      RUN: begin
        bus.in_ready = (out_cnt != OUT_LAST) && (!bus.out_valid || bus.out_ready);
        if (last_fire) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Tap view of the window as it will be after this cycle's shift.
  always_comb begin
    for (int i = 0; i < TAPS - 1; i++) taps[i] = win[i + 1];
    taps[TAPS - 1] = bus.in_sample;
  end

  always_comb begin
    sum   = '0;
    c_ext = '0;
    s_ext = '0;
    prod  = '0;
    for (int i = 0; i < TAPS; i++) begin
      c_ext = {{8{coef_q[i][7]}}, coef_q[i]};
      s_ext = {8'd0, taps[i]};
      prod  = c_ext * s_ext;
      sum   = sum + {{(ACC_W - 16){prod[15]}}, prod};
    end
  end

`ifdef AFFINE_HIGHPREC_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  always_comb begin
    if (sum > SAT_HI)      result = 16'h7fff;
    else if (sum < SAT_LO) result = 16'h8000;
    else                   result = sum[15:0];
  end
`else
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] CLIP_HI = ACC_W'(255);
  logic signed [ACC_W-1:0] rnd;

  always_comb begin
    rnd = (sum + HALF) >>> SHIFT;
    if (rnd[ACC_W-1])      result = 8'd0;
    else if (rnd > CLIP_HI) result = 8'd255;
    else                   result = rnd[7:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: window and coefficients are small flop arrays, not RAM, so they
      // take the reset like any other state.
      for (int i = 0; i < TAPS; i++) begin
        win[i]    <= '0;
        coef_q[i] <= '0;
      end
      fill_cnt       <= '0;
      out_cnt        <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sample <= '0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= last_fire;
      if (state == IDLE && bus.start) begin
        for (int i = 0; i < TAPS; i++) coef_q[i] <= bus.coef[i*8 +: 8];
        fill_cnt <= '0;
        out_cnt  <= '0;
      end
      if (in_fire) begin
        for (int i = 0; i < TAPS; i++) win[i] <= taps[i];
      end
      if (state == FILL && in_fire) fill_cnt <= fill_cnt + 1'b1;
      if (state == RUN) begin
        if (in_fire) begin
          bus.out_sample <= result;
          bus.out_valid  <= 1'b1;
          out_cnt        <= out_cnt + 1'b1;
        end else if (out_fire) begin
          bus.out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_affine_interp_row_filter.sv
// Directed bench for affine_interp_row_filter (TAPS=6, ROW_LEN=4, SHIFT=6) with
// hand-computed expected outputs.
module tb_affine_interp_row_filter;
  localparam int TAPS = 6;
  localparam int ROW  = 4;
  localparam int NIN  = ROW + TAPS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  affine_interp_row_filter_if #(.TAPS(TAPS)) bus ();

  affine_interp_row_filter #(.TAPS(TAPS), .ROW_LEN(ROW), .SHIFT(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] smp   [NIN];
  int         exp_o [ROW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [47:0] pk(input int c0, c1, c2, c3, c4, c5);
    return {8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic begin_row(input logic [47:0] c);
    bus.coef  = c;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("row_busy", bus.busy, 1);
    check("fill_in_ready", bus.in_ready, 1);
  endtask

  // Streams smp[] and checks outputs against exp_o[]; stall_at starts a 5-cycle
  // out_ready=0 window, abort_after returns once that many outputs are taken,
  // start_at pulses start with alt_coef.
  task automatic run_row(input string name, input int stall_at, input int abort_after,
                         input int start_at, input logic [47:0] alt_coef);
    int idx = 0, nout = 0, ndone = 0, cyc = 0;
    bit in_f, out_f, fin = 0;
    while (!fin && cyc < 100) begin
      bus.in_valid  = (idx < NIN);
      bus.in_sample = (idx < NIN) ? smp[idx] : 8'h00;
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
      bus.start     = (cyc == start_at);
      if (cyc == start_at) bus.coef = alt_coef;
      #1;
      in_f  = bus.in_valid && bus.in_ready;
      out_f = bus.out_valid && bus.out_ready;
      if (!bus.out_ready && bus.out_valid && nout < ROW) begin
        check({name, "_stall_in_ready"}, bus.in_ready, 0);
        check({name, "_stall_hold"}, bus.out_sample, exp_o[nout]);
      end
      if (out_f) begin
        if (nout < ROW) check($sformatf("%s_out%0d", name, nout), bus.out_sample, exp_o[nout]);
        nout++;
      end
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (in_f) begin
        idx++;
        if (idx == TAPS - 1) check({name, "_fill_no_valid"}, bus.out_valid, 0);
        if (idx == TAPS)     check({name, "_first_latency"}, bus.out_valid, 1);
      end
      if (bus.done) begin
        ndone++;
        check({name, "_done_at_last"}, nout, ROW);
        check({name, "_done_valid_low"}, bus.out_valid, 0);
        check({name, "_done_idle"}, bus.busy, 0);
        fin = 1;
      end
      if (abort_after > 0 && nout == abort_after) fin = 1;
    end
    check({name, "_row_timeout"}, fin, 1);
    if (abort_after == 0) begin
      bus.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (bus.done) ndone++;
      end
      check({name, "_out_count"}, nout, ROW);
      check({name, "_done_count"}, ndone, 1);
      check({name, "_idle_in_ready"}, bus.in_ready, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.coef      = '0;
    bus.in_valid  = 1'b0;
    bus.in_sample = 8'h00;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity: tap 2 weight 64 passes sample k+2 through.
    smp   = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    exp_o = '{30, 40, 50, 60};
    begin_row(pk(0, 0, 64, 0, 0, 0));
    run_row("ident", 1000, 0, -1, '0);

    // Rounding with negative taps on a flat input.
    smp   = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    exp_o = '{100, 100, 100, 100};
    begin_row(pk(-2, -3, 69, 0, 0, 0));
    run_row("round", 1000, 0, -1, '0);

    // -1275 clips to 0; 6390->100; 6600->103; 6400->100.
    smp   = '{8'd255, 8'd255, 8'd0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    exp_o = '{0, 100, 103, 100};
    begin_row(pk(-2, -3, 69, 0, 0, 0));
    run_row("lowclip", 1000, 0, -1, '0);

    // 20400->319 clips to 255; -2040 and -512 clip to 0; 5120->80.
    smp   = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd0};
    exp_o = '{255, 0, 0, 80};
    begin_row(pk(0, -8, 80, -8, 0, 0));
    run_row("hiclip", 1000, 0, -1, '0);

    // Backpressure: same sequence as the identity row.
    smp   = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    exp_o = '{30, 40, 50, 60};
    begin_row(pk(0, 0, 64, 0, 0, 0));
    run_row("stall", 7, 0, -1, '0);

    // Reset after the third output, then a fresh row.
    begin_row(pk(0, 0, 64, 0, 0, 0));
    run_row("abort", 1000, 3, -1, '0);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_done", bus.done, 0);
    smp   = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    exp_o = '{100, 100, 100, 100};
    begin_row(pk(-2, -3, 69, 0, 0, 0));
    run_row("fresh", 1000, 0, -1, '0);

    // start during RUN with a different coefficient set is ignored.
    smp   = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    exp_o = '{30, 40, 50, 60};
    begin_row(pk(0, 0, 64, 0, 0, 0));
    run_row("ignstart", 1000, 0, 7, pk(0, 0, 0, 64, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
